// File: rtl/countdown_timer_32_pkg.sv
// Shared definitions for the countdown timer slice.
// State encodings and the default counter width.
package countdown_timer_32_pkg;

    localparam int CD_WIDTH = 32;

    typedef enum logic [1:0] {
        CD_IDLE = 2'd0,
        CD_RUN  = 2'd1,
        CD_DONE = 2'd2
    } cd_state_e;

endpackage

// File: rtl/countdown_timer_32_reg.sv
// reg_en_async: WIDTH-bit register, enable, async active-high clear.
// Ports: clk, clr, en, d[WIDTH], q[WIDTH].
module reg_en_async
    import countdown_timer_32_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/countdown_timer_32.sv
// countdown_timer_32: loadable down counter with pause/abort and a one-cycle done.
// Ports: clk, clr (async high), start, load_val, pause, abort -> count, ready, busy, done.
// Option: COUNTDOWN_AUTO_RELOAD_EN makes DONE re-enter RUN with the last load value.
module countdown_timer_32
    import countdown_timer_32_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    cd_state_e        state;

    assign state = cd_state_e'(state_q);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic             reload_en;

    reg_en_async #(.WIDTH(WIDTH)) u_reload (
        .clk (clk),
        .clr (clr),
        .en  (reload_en),
        .d   (load_val),
        .q   (reload_q)
    );
`endif

    reg_en_async #(.WIDTH(2)) u_state (
        .clk (clk),
        .clr (clr),
        .en  (1'b1),
        .d   (state_d),
        .q   (state_q)
    );

    reg_en_async #(.WIDTH(WIDTH)) u_count (
        .clk (clk),
        .clr (clr),
        .en  (1'b1),
        .d   (count_d),
        .q   (count_q)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_en = 1'b0;
`endif
        unique case (state)
            CD_IDLE: begin
                if (abort) begin
                    count_d = '0;
                end else if (start) begin
                    if (load_val != '0) begin
                        count_d = load_val;
                        state_d = CD_RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        reload_en = 1'b1;
`endif
                    end else begin
                        count_d = '0;
                        state_d = CD_DONE;
                    end
                end
            end
            CD_RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = CD_IDLE;
                end else if (!pause) begin
                    // Zero in RUN is unreachable; finish rather than wrap.
                    if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                    end
                    if (count_q <= WIDTH'(1)) begin
                        state_d = CD_DONE;
                    end
                end
            end
            CD_DONE: begin
                count_d = '0;
                state_d = CD_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (!abort && reload_q != '0) begin
                    count_d = reload_q;
                    state_d = CD_RUN;
                end
`endif
            end
            default: begin
                count_d = '0;
                state_d = CD_IDLE;
            end
        endcase
    end

    assign count = count_q;
    assign ready = (state == CD_IDLE);
    assign busy  = (state == CD_RUN);
    assign done  = (state == CD_DONE);

endmodule

// File: tb/tb_countdown_timer_32.sv
// Directed bench for countdown_timer_32.
// Checks reset, countdown, zero load, pause, abort, restart and wraparound edges.
module tb_countdown_timer_32;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] load_val = '0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] count;
    logic        ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    countdown_timer_32 dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .load_val (load_val),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .ready    (ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] c,
                       input logic r, input logic b, input logic d);
        checks++;
        assert ({count, ready, busy, done} === {c, r, b, d})
        else begin
            errors++;
            $error("FAIL %s got cnt=%0h r%0b b%0b d%0b want cnt=%0h r%0b b%0b d%0b",
                   tag, count, ready, busy, done, c, r, b, d);
        end
    endtask

    initial begin
        #1 clr = 1'b1;
        #2 chk("reset_async", 32'd0, 1, 0, 0);
        step();
        clr = 1'b0;
        step();
        chk("reset_idle", 32'd0, 1, 0, 0);

        // load 5
        start = 1'b1;
        load_val = 32'd5;
        step();
        start = 1'b0;
        chk("l5_load", 32'd5, 0, 1, 0);
        for (int i = 4; i >= 1; i--) begin
            step();
            chk("l5_run", 32'(i), 0, 1, 0);
        end
        step();
        chk("l5_done", 32'd0, 0, 0, 1);
        step();
        chk("l5_ready", 32'd0, 1, 0, 0);

        // load 0
        start = 1'b1;
        load_val = 32'd0;
        step();
        start = 1'b0;
        chk("l0_done", 32'd0, 0, 0, 1);
        step();
        chk("l0_idle", 32'd0, 1, 0, 0);

        // load 6, pause at 3 for 3 cycles
        start = 1'b1;
        load_val = 32'd6;
        step();
        start = 1'b0;
        chk("p_load", 32'd6, 0, 1, 0);
        for (int i = 5; i >= 3; i--) begin
            step();
            chk("p_run", 32'(i), 0, 1, 0);
        end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("p_hold", 32'd3, 0, 1, 0);
        end
        pause = 1'b0;
        step();
        chk("p_2", 32'd2, 0, 1, 0);
        step();
        chk("p_1", 32'd1, 0, 1, 0);
        step();
        chk("p_done", 32'd0, 0, 0, 1);
        step();
        chk("p_idle", 32'd0, 1, 0, 0);

        // load 4, abort at 2
        start = 1'b1;
        load_val = 32'd4;
        step();
        start = 1'b0;
        step();
        step();
        chk("a_at2", 32'd2, 0, 1, 0);
        abort = 1'b1;
        step();
        chk("a_idle", 32'd0, 1, 0, 0);
        start = 1'b1;
        load_val = 32'd9;
        step();
        chk("a_start_abort", 32'd0, 1, 0, 0);
        abort = 1'b0;
        start = 1'b0;
        step();
        chk("a_no_done", 32'd0, 1, 0, 0);

        // async clear mid-run at 7
        start = 1'b1;
        load_val = 32'd10;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("c_at7", 32'd7, 0, 1, 0);
        #2 clr = 1'b1;
        #1 chk("c_async", 32'd0, 1, 0, 0);
        #1 clr = 1'b0;
        step();
        chk("c_idle", 32'd0, 1, 0, 0);

        // all-ones load
        start = 1'b1;
        load_val = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        chk("max_load", 32'hFFFF_FFFF, 0, 1, 0);
        step();
        chk("max_dec", 32'hFFFF_FFFE, 0, 1, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("max_abort", 32'd0, 1, 0, 0);

        // start held across DONE
        start = 1'b1;
        load_val = 32'd1;
        step();
        chk("h_load", 32'd1, 0, 1, 0);
        step();
        chk("h_done", 32'd0, 0, 0, 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        step();
        chk("h_reload", 32'd1, 0, 1, 0);
        start = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("h_abort", 32'd0, 1, 0, 0);
`else
        step();
        chk("h_idle", 32'd0, 1, 0, 0);
        step();
        chk("h_retrig", 32'd1, 0, 1, 0);
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("h_abort", 32'd0, 1, 0, 0);
`endif

        // load 3: periodic or one-shot
        start = 1'b1;
        load_val = 32'd3;
        step();
        start = 1'b0;
        chk("r_load", 32'd3, 0, 1, 0);
        step();
        step();
        step();
        chk("r_done1", 32'd0, 0, 0, 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        step();
        chk("r_again", 32'd3, 0, 1, 0);
        step();
        step();
        step();
        chk("r_done2", 32'd0, 0, 0, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("r_stop", 32'd0, 1, 0, 0);
`else
        step();
        chk("r_oneshot", 32'd0, 1, 0, 0);
`endif
        step();
        chk("end_idle", 32'd0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
